// File: rtl/awg_pkg.sv
// Shared definitions for the AWG serial link (transmit and receive paths).
// Provides the UART frame width, the UART FSM state type and a helper that
// derives the baud divider from the clock and line rates.
package awg_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  // Integer divide: the line rate is approximated by whole clock cycles per bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_transmitter_sync_fifo.sv
// sync_fifo: single-clock byte queue used by the UART transmitter.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   push_i, wdata_i write request and data (ignored when full)
//   pop_i           read request (ignored when empty)
//   rdata_o         head-of-queue data (valid when not empty)
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries, 0..DEPTH
// A push into an empty queue only becomes visible one cycle later; there is
// no fall-through path from wdata_i to rdata_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == (AW + 1)'(DEPTH));
  assign empty_o   = (count_q == {(AW + 1){1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rptr_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {(AW + 1){1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; cleared on reset so stale bytes never reach the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter with a small input byte queue.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset (aborts any frame in flight)
//   tx_data   byte to send
//   tx_valid  tx_data valid this cycle
//   tx_ready  queue can accept; byte taken when tx_valid && tx_ready
//   uart_tx   serial line, idle high, registered
//   tx_busy   frame on the line or bytes still queued
module uart_transmitter
  import awg_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       tx_busy
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam int FAW = $clog2(FIFO_DEPTH);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic          fifo_push_s;
  logic          fifo_pop_s;
  logic [7:0]    fifo_rdata_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [FAW:0]  fifo_count_s;
  logic          baud_last_s;

  assign tx_ready    = !fifo_full_s;
  assign fifo_push_s = tx_valid && !fifo_full_s;
  assign uart_tx     = tx_q;
  assign tx_busy     = (state_q != UART_IDLE) || (fifo_count_s != {(FAW + 1){1'b0}});
  assign baud_last_s = (baud_q == BAUD_LAST);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push_s),
    .wdata_i(tx_data),
    .pop_i  (fifo_pop_s),
    .rdata_o(fifo_rdata_s),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s),
    .count_o(fifo_count_s)
  );

  // Frame sequencing. tx_d is the line level for the *next* cycle, so the
  // registered output changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      UART_IDLE: begin
        tx_d      = 1'b1;
        baud_d    = {CW{1'b0}};
        bit_idx_d = 3'd0;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_rdata_s;
          state_d    = UART_START;
          tx_d       = 1'b0;
        end else begin
          state_d = UART_IDLE;
        end
      end
      UART_START: begin
        if (baud_last_s) begin
          baud_d    = {CW{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = UART_DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
          tx_d   = 1'b0;
        end
      end
      UART_DATA: begin
        if (baud_last_s) begin
          baud_d = {CW{1'b0}};
          if (bit_idx_q == LAST_BIT) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            // LSB first: drop the bit just sent, present the next one.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      UART_STOP: begin
        if (baud_last_s) begin
          baud_d = {CW{1'b0}};
          // Queued byte follows immediately with no idle gap.
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            shift_d    = fifo_rdata_s;
            state_d    = UART_START;
            tx_d       = 1'b0;
          end else begin
            state_d = UART_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
          tx_d   = 1'b1;
        end
      end
      default: begin
        state_d = UART_IDLE;
        baud_d  = {CW{1'b0}};
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, counters, shift register and the registered line driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UART_IDLE;
      baud_q    <= {CW{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter. A frame-level reference model
// (byte queue + position within a 10-bit frame) predicts the line, tx_ready
// and tx_busy every cycle; a behavioural receiver decodes the line and
// compares every completed byte against the model.
module tb_uart_transmitter;

  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx;
  logic       tx_busy;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of accepted bytes and the frame currently on the line.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = 8'h00;
  int         m_accepted = 0;

  function automatic logic exp_line();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot - 1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_pos    = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    bit can_take;
    can_take = (m_q.size() < DEPTH);
    if (m_active && m_pos == FRAME - 1) begin
      m_active = 1'b0;
      if (m_q.size() > 0) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else if (m_active) begin
      m_pos++;
    end else if (m_q.size() > 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (v && can_take) begin
      m_q.push_back(d);
      m_accepted++;
    end
  endtask

  // Behavioural receiver sampling mid-bit.
  bit         r_busy   = 1'b0;
  int         r_t      = 0;
  logic [7:0] r_byte   = 8'h00;
  int         r_frames = 0;

  task automatic rx_step();
    int k;
    if (!r_busy) begin
      if (uart_tx === 1'b0) begin
        r_busy = 1'b1;
        r_t    = 0;
      end
    end else begin
      r_t++;
      if (r_t % CPB == CPB / 2) begin
        k = r_t / CPB;
        if (k == 0) begin
          check("rx_start", uart_tx, 1'b0);
        end else if (k <= 8) begin
          r_byte[k - 1] = uart_tx;
        end else begin
          check("rx_stop", uart_tx, 1'b1);
          check("rx_data", r_byte, m_cur);
          r_frames++;
          r_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    tx_valid = v;
    tx_data  = d;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(v, d);
    #1;
    check("uart_tx", uart_tx, exp_line());
    check("tx_ready", tx_ready, (m_q.size() < DEPTH));
    check("tx_busy", tx_busy, (m_active || m_q.size() != 0));
    if (rst) r_busy = 1'b0;
    else rx_step();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_active || m_q.size() != 0) && guard < FRAME * (DEPTH + 3)) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    tick(1'b0, 8'h00);
    check("drain_busy", tx_busy, 1'b0);
  endtask

  task automatic push_wait(input logic [7:0] d);
    int a0;
    int guard;
    a0 = m_accepted;
    guard = 0;
    while (m_accepted == a0 && guard < 2 * FRAME) begin
      tick(1'b1, d);
      guard++;
    end
    check("push_accepted", m_accepted - a0, 1);
  endtask

  initial begin
    logic [7:0] burst [5];
    int f0;
    int a0;
    int guard;
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55;
    burst[3] = 8'h3C; burst[4] = 8'h81;

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) tick(1'b0, 8'h00);
    rst = 1'b0;
    repeat (3) tick(1'b0, 8'h00);

    // 1: single byte, full frame then idle.
    f0 = r_frames;
    tick(1'b1, 8'hA5);
    drain();
    check("t1_frames", r_frames - f0, 1);

    // 2: burst on consecutive cycles, plus one extra that must wait for space.
    f0 = r_frames;
    for (int i = 0; i < 5; i++) tick(1'b1, burst[i]);
    push_wait(8'h7E);
    drain();
    check("t2_frames", r_frames - f0, 6);

    // 3: next byte offered exactly on the last stop cycle.
    f0 = r_frames;
    tick(1'b1, 8'h12);
    guard = 0;
    while (!(m_active && m_pos == FRAME - 1) && guard < 2 * FRAME) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    tick(1'b1, 8'h34);
    check("t3_gap_line", uart_tx, 1'b1);
    drain();
    check("t3_frames", r_frames - f0, 2);

    // 4: reset during data bit 3 of 0xC3 with two bytes queued.
    tick(1'b1, 8'hC3);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    guard = 0;
    while (!(m_active && m_cur == 8'hC3 && m_pos == 4 * CPB + 3) && guard < 2 * FRAME) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    model_reset();
    r_busy = 1'b0;
    repeat (2) tick(1'b0, 8'h00);
    rst = 1'b0;
    f0 = r_frames;
    repeat (2 * FRAME) tick(1'b0, 8'h00);
    check("t4_no_frame", r_frames - f0, 0);

    // 5: 256 random bytes with random valid gaps, decoded by the receiver.
    f0 = r_frames;
    a0 = m_accepted;
    guard = 0;
    while (m_accepted - a0 < 256 && guard < 40000) begin
      tick(($urandom_range(0, 3) != 0), 8'($urandom));
      guard++;
    end
    check("t5_accepted", m_accepted - a0, 256);
    drain();
    check("t5_frames", r_frames - f0, 256);

    // 6: valid held with a full queue; held bytes must not overwrite.
    f0 = r_frames;
    a0 = m_accepted;
    for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom));
    for (int i = 0; i < 50; i++) tick(1'b1, 8'($urandom));
    drain();
    check("t6_frames", r_frames - f0, m_accepted - a0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
